// File: rtl/vanilla_pc_hist_arbiter.sv
// rtl/vanilla_pc_hist_arbiter.sv - round-robin profiling-counter RMW arbiter with clear-on-read drain
module vanilla_pc_hist_arbiter #(
    parameter  int num_req_p       = 4,
    parameter  int num_ops_p       = 32,
    parameter  int counter_width_p = 32,
    localparam int els_lp          = num_req_p * num_ops_p,
    localparam int idx_width_lp    = $clog2(els_lp),
    localparam int op_width_lp     = $clog2(num_ops_p),
    localparam int req_width_lp    = $clog2(num_req_p)
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic [num_req_p-1:0]               v_i,
    input  logic [num_req_p*op_width_lp-1:0]   op_i,
    output logic [num_req_p-1:0]               ready_o,
    input  logic                               drain_v_i,
    output logic                               drain_busy_o,
    output logic                               data_v_o,
    output logic [counter_width_p-1:0]         data_o,
    output logic [idx_width_lp-1:0]            data_idx_o,
    input  logic                               data_yumi_i,
    output logic                               drain_done_o
);

    typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_READ, S_OUT, S_DONE} state_e;

    state_e                      state_q, state_d;
    logic [req_width_lp-1:0]     ptr_q, ptr_d;
    logic [idx_width_lp-1:0]     drain_idx_q, drain_idx_d;
    logic                        w_v_q, fwd_q;
    logic [idx_width_lp-1:0]     w_idx_q;
    logic [counter_width_p-1:0]  fwd_data_q, rd_data_q;
    logic [counter_width_p-1:0]  mem_q [els_lp];

    logic                        grant_v;
    logic [req_width_lp-1:0]     grant_id;
    logic [idx_width_lp-1:0]     grant_idx, rd_addr, wr_addr;
    logic [counter_width_p-1:0]  old_cnt, new_cnt, wr_data;
    logic                        wr_en, last_entry;

    // Round-robin search starting at ptr_q; index arithmetic wraps since num_req_p is a power of 2
    always_comb begin
        grant_v  = 1'b0;
        grant_id = ptr_q;
        if (state_q == S_IDLE) begin
            for (int k = 0; k < num_req_p; k++) begin
                if (!grant_v && v_i[ptr_q + req_width_lp'(k)]) begin
                    grant_v  = 1'b1;
                    grant_id = ptr_q + req_width_lp'(k);
                end
            end
        end
        grant_idx = {grant_id, op_i[grant_id*op_width_lp +: op_width_lp]};
        ptr_d     = grant_v ? grant_id + req_width_lp'(1) : ptr_q;
        ready_o   = '0;
        if (grant_v) ready_o[grant_id] = 1'b1;
    end

    // Stage W: forwarded value wins over the RAM read when the previous write hit the same index
    always_comb begin
        old_cnt    = fwd_q ? fwd_data_q : rd_data_q;
        new_cnt    = (&old_cnt) ? old_cnt : old_cnt + counter_width_p'(1);
        rd_addr    = (state_q == S_IDLE) ? grant_idx : drain_idx_q;
        wr_en      = w_v_q | ((state_q == S_OUT) & data_yumi_i);
        wr_addr    = w_v_q ? w_idx_q : drain_idx_q;
        wr_data    = w_v_q ? new_cnt : '0;
        last_entry = (drain_idx_q == idx_width_lp'(els_lp - 1));
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptr_q       <= '0;
            drain_idx_q <= '0;
            w_v_q       <= 1'b0;
            w_idx_q     <= '0;
            fwd_q       <= 1'b0;
            fwd_data_q  <= '0;
            rd_data_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            drain_idx_q <= drain_idx_d;
            w_v_q       <= grant_v;
            w_idx_q     <= grant_idx;
            fwd_q       <= w_v_q & grant_v & (w_idx_q == grant_idx);
            fwd_data_q  <= new_cnt;
            rd_data_q   <= mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        drain_idx_d = drain_idx_q;
        case (state_q)
            S_IDLE:  if (drain_v_i) state_d = S_FLUSH;
            S_FLUSH: begin
                drain_idx_d = '0;
                state_d     = S_READ;
            end
            S_READ:  state_d = S_OUT;
            S_OUT: begin
                if (data_yumi_i) begin
                    drain_idx_d = drain_idx_q + idx_width_lp'(1);
                    state_d     = last_entry ? S_DONE : S_READ;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        drain_busy_o = (state_q == S_FLUSH) | (state_q == S_READ) | (state_q == S_OUT);
        data_v_o     = (state_q == S_OUT);
        drain_done_o = (state_q == S_DONE);
        data_o       = data_v_o ? rd_data_q : '0;
        data_idx_o   = data_v_o ? drain_idx_q : '0;
    end

endmodule

// File: tb/tb_vanilla_pc_hist_arbiter.sv
// tb/tb_vanilla_pc_hist_arbiter.sv - scoreboard bench for the profiling-counter arbiter
module tb_vanilla_pc_hist_arbiter;

    localparam int NR  = 4;
    localparam int OW  = 5;
    localparam int IW  = 7;
    localparam int CW  = 32;
    localparam int ELS = 128;

    typedef struct {
        int          idx;
        logic [CW-1:0] val;
    } ent_t;

    logic              clk = 1'b0;
    logic              reset_n_i;
    logic [NR-1:0]     v_i;
    logic [NR*OW-1:0]  op_i;
    logic [NR-1:0]     ready_o;
    logic              drain_v_i;
    logic              drain_busy_o;
    logic              data_v_o;
    logic [CW-1:0]     data_o;
    logic [IW-1:0]     data_idx_o;
    logic              data_yumi_i;
    logic              drain_done_o;

    int                n_checks = 0;
    int                n_pass   = 0;
    logic [CW-1:0]     m_cnt [ELS];
    int                m_ptr;
    ent_t              exp_q [$];

    vanilla_pc_hist_arbiter #(.num_req_p(NR), .num_ops_p(32), .counter_width_p(CW)) dut (
        .clk_i(clk), .reset_n_i(reset_n_i), .v_i(v_i), .op_i(op_i), .ready_o(ready_o),
        .drain_v_i(drain_v_i), .drain_busy_o(drain_busy_o), .data_v_o(data_v_o),
        .data_o(data_o), .data_idx_o(data_idx_o), .data_yumi_i(data_yumi_i),
        .drain_done_o(drain_done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One stimulus cycle; the model arbitrates and counts independently of the DUT
    task automatic cycle_req(input logic [NR-1:0] v, input logic [NR*OW-1:0] ops, input bit drain);
        int g;
        int idx;
        logic [NR-1:0] exp_rdy;
        @(negedge clk);
        v_i = v; op_i = ops; drain_v_i = drain;
        #1;
        g = -1;
        for (int k = 0; k < NR; k++)
            if (g < 0 && v[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("ready", ready_o, exp_rdy);
        if (g >= 0) begin
            idx = g * 32 + int'(ops[g*OW +: OW]);
            if (m_cnt[idx] != {CW{1'b1}}) m_cnt[idx] = m_cnt[idx] + 1;
            m_ptr = (g + 1) % NR;
        end
        @(posedge clk);
        #1;
        v_i = '0; drain_v_i = 1'b0;
    endtask

    task automatic run_drain(input bit started, input bit check_vals, input int stall_idx, input int abort_idx);
        int            cyc;
        int            dones;
        int            stall_cnt;
        bit            blocked_ok;
        bit            hold_ok;
        bit            aborted;
        logic [CW-1:0] hold_d;
        logic [IW-1:0] hold_i;
        ent_t          e;
        if (!started) begin
            @(negedge clk);
            drain_v_i = 1'b1;
            @(posedge clk);
            #1;
            drain_v_i = 1'b0;
        end
        for (int i = 0; i < ELS; i++) exp_q.push_back('{i, m_cnt[i]});
        v_i = '1;
        cyc = 0; dones = 0; stall_cnt = 0; blocked_ok = 1; hold_ok = 1; aborted = 0;
        hold_d = '0; hold_i = '0;
        while (cyc < 600) begin
            @(negedge clk);
            cyc++;
            op_i = NR*OW'($urandom);
            data_yumi_i = 1'b0;
            #1;
            if (ready_o != '0) blocked_ok = 0;
            if (drain_done_o) begin
                dones++;
                check("busy_at_done", drain_busy_o, 0);
                v_i = '0;
                break;
            end
            if (data_v_o) begin
                if (int'(data_idx_o) == abort_idx) begin
                    v_i = '0;
                    reset_n_i = 1'b0;
                    #1;
                    check("rst_outputs", {ready_o, data_v_o, data_o, data_idx_o, drain_busy_o, drain_done_o}, 0);
                    @(negedge clk);
                    reset_n_i = 1'b1;
                    #1;
                    check("idle_after_rst", {drain_busy_o, data_v_o}, 0);
                    m_ptr = 0;
                    exp_q.delete();
                    aborted = 1;
                    break;
                end
                if (int'(data_idx_o) == stall_idx && stall_cnt < 10) begin
                    if (stall_cnt == 0) begin
                        hold_d = data_o; hold_i = data_idx_o;
                    end else if (data_o !== hold_d || data_idx_o !== hold_i) begin
                        hold_ok = 0;
                    end
                    stall_cnt++;
                end else if (exp_q.size() == 0) begin
                    check("extra_entry", 1, 0);
                    break;
                end else begin
                    e = exp_q.pop_front();
                    check("drain_idx", 64'(data_idx_o), 64'(e.idx));
                    if (check_vals) check("drain_val", data_o, e.val);
                    m_cnt[e.idx] = '0;
                    data_yumi_i = 1'b1;
                end
            end
        end
        v_i = '0;
        data_yumi_i = 1'b0;
        check("ready_blocked", blocked_ok, 1);
        if (stall_idx >= 0) check("stall_hold", {hold_ok, 7'(stall_cnt)}, {1'b1, 7'd10});
        if (!aborted) begin
            check("done_pulses", dones, 1);
            check("queue_empty", exp_q.size(), 0);
            exp_q.delete();
            @(negedge clk);
            #1;
            check("done_one_cycle", drain_done_o, 0);
        end
    endtask

    initial begin
        reset_n_i = 1'b0; v_i = '0; op_i = '0; drain_v_i = 1'b0; data_yumi_i = 1'b0;
        m_ptr = 0;
        for (int i = 0; i < ELS; i++) m_cnt[i] = '0;
        #1;
        check("reset_outputs", {ready_o, data_v_o, data_o, data_idx_o, drain_busy_o, drain_done_o}, 0);
        repeat (3) @(negedge clk);
        reset_n_i = 1'b1;

        // Clearing drain: RAM is undefined, so only the index order and done pulse are checked
        run_drain(0, 0, -1, -1);

        repeat (5) cycle_req(4'b0001, 20'(3), 0);
        run_drain(0, 1, -1, -1);

        repeat (8) cycle_req(4'b1111, 20'(0), 0);
        run_drain(0, 1, -1, -1);

        for (int i = 0; i < 6; i++)
            cycle_req((i % 2 == 0) ? 4'b0010 : 4'b0100, {5'd0, 5'd7, 5'd7, 5'd0}, 0);
        repeat (4) cycle_req(4'b0010, {5'd0, 5'd0, 5'd7, 5'd0}, 0);
        run_drain(0, 1, -1, -1);

        @(negedge clk);
        dut.mem_q[5] = 32'hFFFF_FFFE;
        m_cnt[5]     = 32'hFFFF_FFFE;
        repeat (3) cycle_req(4'b0001, 20'(5), 0);
        run_drain(0, 1, -1, -1);

        cycle_req(4'b1000, {5'd9, 15'd0}, 0);
        cycle_req(4'b0001, 20'(1), 1);
        run_drain(1, 1, -1, -1);
        run_drain(0, 1, -1, -1);

        for (int i = 0; i < 20; i++) cycle_req(NR'($urandom), NR*OW'($urandom), 0);
        repeat (4) cycle_req(4'b0001, 20'(2), 0);
        run_drain(0, 1, 2, 5);
        run_drain(0, 1, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
